// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters feed a registered pixel-request
// stage, a sync/visible flag stage, and a registered pin stage 2 cycles later.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        CLOCK25,
  input  logic        RESETN,
  input  logic        PLLLOCKED,
  output logic        REQ,
  output logic [9:0]  XPOS,
  output logic [9:0]  YPOS,
  input  logic [23:0] RGBIN,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANKN,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        FRAMESTART
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {S_HOLD, S_RUN} state_t;

  state_t     r_state;
  logic [9:0] r_hcnt, r_vcnt;
  logic [9:0] w_hnext, w_vnext;
  logic       w_vis, w_hsync, w_vsync;
  logic       r_hs0_n, r_vs0_n, r_hs1_n, r_vs1_n, r_vis1;

  // Leaving S_HOLD always restarts the raster at (0,0).
  always_comb begin
    w_hnext = '0;
    w_vnext = '0;
    if (r_state == S_RUN) begin
      if (r_hcnt == H_LAST) begin
        w_hnext = '0;
        w_vnext = (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
      end else begin
        w_hnext = r_hcnt + 10'd1;
        w_vnext = r_vcnt;
      end
    end
  end

  assign w_vis   = (w_hnext < H_VIS) && (w_vnext < V_VIS);
  assign w_hsync = (w_hnext >= H_SS) && (w_hnext < H_SE);
  assign w_vsync = (w_vnext >= V_SS) && (w_vnext < V_SE);

  always_ff @(posedge CLOCK25 or negedge RESETN) begin
    if (!RESETN) begin
      r_state    <= S_HOLD;
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      REQ        <= 1'b0;
      XPOS       <= '0;
      YPOS       <= '0;
      FRAMESTART <= 1'b0;
      r_hs0_n    <= 1'b1;
      r_vs0_n    <= 1'b1;
      r_hs1_n    <= 1'b1;
      r_vs1_n    <= 1'b1;
      r_vis1     <= 1'b0;
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
      VGA_BLANKN <= 1'b0;
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
    end else if (!PLLLOCKED) begin
      // Counters hold; every pipeline stage is flushed so nothing stale survives relock.
      r_state    <= S_HOLD;
      REQ        <= 1'b0;
      XPOS       <= '0;
      YPOS       <= '0;
      FRAMESTART <= 1'b0;
      r_hs0_n    <= 1'b1;
      r_vs0_n    <= 1'b1;
      r_hs1_n    <= 1'b1;
      r_vs1_n    <= 1'b1;
      r_vis1     <= 1'b0;
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
      VGA_BLANKN <= 1'b0;
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
    end else begin
      r_state    <= S_RUN;
      r_hcnt     <= w_hnext;
      r_vcnt     <= w_vnext;
      REQ        <= w_vis;
      XPOS       <= w_vis ? w_hnext : '0;
      YPOS       <= w_vis ? w_vnext : '0;
      FRAMESTART <= (w_hnext == '0) && (w_vnext == '0);
      r_hs0_n    <= ~w_hsync;
      r_vs0_n    <= ~w_vsync;
      r_hs1_n    <= r_hs0_n;
      r_vs1_n    <= r_vs0_n;
      r_vis1     <= REQ;
      VGA_HS     <= r_hs1_n;
      VGA_VS     <= r_vs1_n;
      VGA_BLANKN <= r_vis1;
      {VGA_R, VGA_G, VGA_B} <= r_vis1 ? RGBIN : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: scaled-geometry DUT checked every cycle against a
// raster-position model, plus a default-geometry DUT checked over its first line.
module tb_vga_timing_gen;

  localparam int HA = 40, HF = 4, HSW = 8, HB = 6;
  localparam int VA = 20, VF = 3, VSW = 2, VB = 5;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int NCYC = 7000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll = 1'b1;
  logic [23:0] rgbin = '0;

  logic        req, hs, vs, bl, fs;
  logic [9:0]  xpos, ypos;
  logic [7:0]  vr, vg, vb;

  logic        full_lock = 1'b1;
  logic [23:0] full_rgb = '0;
  logic        f_req, f_hs, f_vs, f_bl, f_fs;
  logic [9:0]  f_x, f_y;
  logic [7:0]  f_r, f_g, f_b;

  always #20 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) u_dut (
    .CLOCK25(clk), .RESETN(rst_n), .PLLLOCKED(pll),
    .REQ(req), .XPOS(xpos), .YPOS(ypos), .RGBIN(rgbin),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANKN(bl),
    .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .FRAMESTART(fs)
  );

  vga_timing_gen u_full (
    .CLOCK25(clk), .RESETN(rst_n), .PLLLOCKED(full_lock),
    .REQ(f_req), .XPOS(f_x), .YPOS(f_y), .RGBIN(full_rgb),
    .VGA_HS(f_hs), .VGA_VS(f_vs), .VGA_BLANKN(f_bl),
    .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .FRAMESTART(f_fs)
  );

  typedef struct packed {
    logic        req;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
  } rec_t;

  rec_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit vis(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic bit hsync(input int p);
    return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HSW);
  endfunction

  function automatic bit vsync(input int p);
    return ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VSW);
  endfunction

  function automatic logic [23:0] pix(input int p);
    logic [7:0] x, y;
    x = 8'(p % HT);
    y = 8'(p / HT);
    return {x, y ^ 8'h3C, x + y};
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    return r;
  endfunction

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    rec_t m;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        m = q.pop_front();
        chk("REQ", 32'(req), 32'(m.req));
        chk("XPOS", 32'(xpos), 32'(m.x));
        chk("YPOS", 32'(ypos), 32'(m.y));
        chk("FRAMESTART", 32'(fs), 32'(m.fs));
        chk("VGA_HS", 32'(hs), 32'(m.hs));
        chk("VGA_VS", 32'(vs), 32'(m.vs));
        chk("VGA_BLANKN", 32'(bl), 32'(m.bl));
        chk("VGA_RGB", 32'({vr, vg, vb}), 32'(m.rgb));
      end
    end
  end

  // Stimulus and reference model: the raster is a position 0..FRAME-1 that
  // restarts after any unlocked/reset edge; pins show the position from 2 edges back.
  initial begin
    int   pos = 0;
    bit   running = 1'b0;
    int   lrun = 0;
    int   p0 = 0, p1 = 0, p2 = 0;
    int   drop_left = 0;
    int   rst_hold = 3;
    bit   did_drop = 1'b0, did_rst = 1'b0;
    rec_t e;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end
      if (!did_drop && c > FRAME && lrun >= 1 && p0 == 10 * HT + 30) begin
        drop_left = 50;
        did_drop  = 1'b1;
      end
      if (c > 3800 && drop_left == 0 && $urandom_range(0, 199) == 0)
        drop_left = int'($urandom_range(1, 40));
      pll = (drop_left == 0);
      if (drop_left > 0) drop_left--;
      rgbin = (lrun >= 2 && vis(p1)) ? pix(p1) : 24'($urandom);

      @(posedge clk);
      if (!rst_n || !pll) begin
        running = 1'b0;
        lrun    = 0;
        q.push_back(idle_rec());
      end else begin
        pos     = running ? (pos + 1) % FRAME : 0;
        running = 1'b1;
        lrun++;
        p2 = p1;
        p1 = p0;
        p0 = pos;
        e  = idle_rec();
        if (vis(pos)) begin
          e.req = 1'b1;
          e.x   = 10'(pos % HT);
          e.y   = 10'(pos / HT);
        end
        e.fs = (pos == 0);
        if (lrun >= 3) begin
          e.hs  = !hsync(p2);
          e.vs  = !vsync(p2);
          e.bl  = vis(p2);
          e.rgb = vis(p2) ? pix(p2) : '0;
        end
        q.push_back(e);
        if (!did_rst && c > 2600 && lrun >= 3 && hsync(p2)) begin
          #3;
          chk("pre_reset_hs_low", 32'(hs), 0);
          rst_n = 1'b0;
          #1;
          chk("async_rst_hs", 32'(hs), 1);
          chk("async_rst_vs", 32'(vs), 1);
          chk("async_rst_blankn", 32'(bl), 0);
          chk("async_rst_rgb", 32'({vr, vg, vb}), 0);
          chk("async_rst_req", 32'(req), 0);
          chk("async_rst_pos", 32'({xpos, ypos}), 0);
          chk("async_rst_fs", 32'(fs), 0);
          rst_hold = 2;
          did_rst  = 1'b1;
        end
      end
    end
    @(posedge clk);
    #2;
    chk("did_drop", 32'(did_drop), 1);
    chk("did_reset", 32'(did_rst), 1);
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Default 640x480 geometry: first-line timing from reset release.
  initial begin
    int fs_edge = -1, first_req = -1, req_cnt = 0;
    int hs_fall = -1, hs_low = 0, bl_first = -1, bl_cnt = 0;
    wait (rst_n === 1'b1);
    for (int e = 1; e <= 810; e++) begin
      @(posedge clk);
      #1;
      if (f_fs && fs_edge < 0) fs_edge = e;
      if (f_req && first_req < 0) first_req = e;
      if (!f_hs && hs_fall < 0) hs_fall = e;
      if (f_bl && bl_first < 0) bl_first = e;
      if (e <= 800) begin
        if (f_req) req_cnt++;
        if (!f_hs) hs_low++;
        if (f_bl) bl_cnt++;
      end
    end
    chk("full_framestart_edge", fs_edge, 1);
    chk("full_first_req_edge", first_req, 1);
    chk("full_req_per_line", req_cnt, 640);
    chk("full_hs_start_after_req", hs_fall - first_req, 658);
    chk("full_hs_low_width", hs_low, 96);
    chk("full_first_blankn_edge", bl_first, 3);
    chk("full_blankn_per_line", bl_cnt, 640);
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch widths in pixels (line total 800).
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP 10, V_SYNC 2, V_BP 33: vertical porch and sync widths in lines (frame total 525).
REQ-005 SHALL have port CLOCK25 input 1: the single clock, the 25.175 MHz pixel clock; all logic is on its rising edge.
REQ-006 SHALL have port RESETN input 1: asynchronous, active-low reset.
REQ-007 SHALL have port PLLLOCKED input 1: pixel clock stable; timing is held while low.
REQ-008 SHALL have port REQ output 1: pixel request, high while counters are in the visible region.
REQ-009 SHALL have port XPOS output 10: requested pixel column, valid while REQ=1.
REQ-010 SHALL have port YPOS output 10: requested pixel row, valid while REQ=1.
REQ-011 SHALL have port RGBIN input 24: pixel data {R[7:0],G[7:0],B[7:0]}, supplied exactly 1 cycle after the matching REQ/XPOS/YPOS.
REQ-012 SHALL have port VGA_HS output 1: horizontal sync, active low.
REQ-013 SHALL have port VGA_VS output 1: vertical sync, active low.
REQ-014 SHALL have port VGA_BLANKN output 1: high during visible pixels at the pins.
REQ-015 SHALL have port VGA_R, VGA_G, VGA_B output 8 each: colour to the DAC.
REQ-016 SHALL have port FRAMESTART output 1: 1-cycle pulse when the counters reach (0,0).

Function
REQ-017 hcnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters), wrapping to 0; vcnt SHALL increment only on that wrap and wrap 0 after V_TOTAL-1.
REQ-018 Both counters SHALL be 10 bits wide; no value beyond total-1 shall occur.
REQ-019 Each line SHALL be segmented as: visible hcnt<H_ACTIVE, front porch, sync H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, back porch; vertical segmentation SHALL be the same scheme on vcnt.
REQ-020 REQ, XPOS, YPOS and FRAMESTART SHALL be registered and aligned with the counter value (stage 0); XPOS/YPOS SHALL be 0 while REQ=0.
REQ-021 Stage 1 SHALL register the stage-0 hsync, vsync and visible flags; stage 2 SHALL register them to VGA_HS, VGA_VS and VGA_BLANKN.
REQ-022 Stage 2 SHALL register RGBIN to VGA_R/G/B when the stage-1 visible flag = 1, else 0, so that pins are 2 cycles after the REQ.
REQ-023 While PLLLOCKED=0, the counters SHALL freeze, REQ and FRAMESTART SHALL be 0, and the pins SHALL be driven HS=1, VS=1, BLANKN=0, RGB=0.
REQ-024 On PLLLOCKED 0->1, the counters SHALL restart from (0,0) on the next cycle, with a FRAMESTART pulse.
REQ-025 The pipeline SHALL be flushed to idle values when PLLLOCKED=0, and no stale pixel shall reach the pins.
REQ-026 At the wrap of both counters on the same edge (799,524 -> 0,0), FRAMESTART SHALL be 1 for exactly that cycle.

Reset
REQ-027 RESETN=0 SHALL immediately clear hcnt, vcnt, REQ, XPOS, YPOS, FRAMESTART, VGA_BLANKN, VGA_R/G/B to 0 and set VGA_HS, VGA_VS to 1.
REQ-028 After RESETN deassertion with PLLLOCKED=1, the first edge SHALL produce counters (0,0) with FRAMESTART=1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame, with no partial sync pulse continuing.

Verification
REQ-030 Reset release with PLLLOCKED=1: FRAMESTART at cycle 1; next FRAMESTART exactly 420000 cycles later.
REQ-031 One line: REQ high for 640 cycles; VGA_HS low for 96 cycles starting 658 cycles after the first REQ (656+2 pipeline); period 800.
REQ-032 One frame: VGA_VS low for 2 lines (1600 cycles) starting at line 490+pipeline; BLANKN high for 480 lines only.
REQ-033 RGBIN = f(XPOS,YPOS) delayed 1 cycle: VGA_R/G/B equals f at each visible pin cycle; 0 at pixel (639->640) blank boundary.
REQ-034 PLLLOCKED dropped at (300,200) for 50 cycles: pins idle within 2 cycles; on relock, counters restart at (0,0) with FRAMESTART.
REQ-035 RESETN pulsed low asynchronously mid-sync: VGA_HS=1 immediately, without waiting for a clock edge.
